// File: rtl/value_bcd_digits_pkg.sv
// ============================================================================
// value_bcd_digits_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the numeric overlay digit generator and
//           the overlay window block that consumes its digits.
// Contents:
//   state_t        - conversion FSM states (IDLE, ABS, SHIFT, COMMIT)
//   BCD_W          - width of one BCD digit (4)
//   BCD_N          - number of BCD nibbles kept by the engine (5, up to 99999)
//   BCD_BITS       - total BCD field width (BCD_W * BCD_N)
//   SYM_MINUS      - overlay symbol code for the minus sign
//   SYM_BLANK      - overlay symbol code for a blank cell
//   add3_if_ge5()  - double-dabble nibble correction
// ============================================================================
package value_bcd_digits_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABS    = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int BCD_W    = 4;
    localparam int BCD_N    = 5;
    localparam int BCD_BITS = BCD_W * BCD_N;

    // Symbol codes above the decimal range, shared with the window block.
    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_BLANK = 4'd11;

    // A nibble of 5 or more would exceed 9 after the next doubling, so it is
    // pre-corrected by +3 to carry into the next decade on the shift.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] i_nib);
        return (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    endfunction

endpackage

// File: rtl/value_bcd_digits_dd_step.sv
// ============================================================================
// dd_step
// ----------------------------------------------------------------------------
// Purpose : One combinational double-dabble iteration. Every BCD nibble that
//           is 5 or more gets +3, then the whole {bcd, binary} register is
//           shifted left by one bit.
// Parameters:
//   WIDTH    - number of binary bits still to be shifted into the BCD field
// Ports:
//   i_shift  in  BCD_BITS+WIDTH  {5 BCD nibbles, binary remainder}
//   o_shift  out BCD_BITS+WIDTH  register after correction and shift
// ============================================================================
module dd_step
    import value_bcd_digits_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [BCD_BITS+WIDTH-1:0] i_shift,
    output logic [BCD_BITS+WIDTH-1:0] o_shift
);

    logic [BCD_BITS+WIDTH-1:0] w_adj;

    always_comb begin
        w_adj = i_shift;
        for (int k = 0; k < BCD_N; k++) begin
            w_adj[WIDTH + k*BCD_W +: BCD_W] =
                add3_if_ge5(i_shift[WIDTH + k*BCD_W +: BCD_W]);
        end
        o_shift = {w_adj[BCD_BITS+WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/value_bcd_digits.sv
// ============================================================================
// value_bcd_digits
// ----------------------------------------------------------------------------
// Purpose : Converts a signed two's-complement measurement into a sign flag
//           and four decimal digits for the on-screen numeric overlay. The
//           conversion is an iterative double-dabble (one bit per clock);
//           outputs only change together in the COMMIT cycle so the overlay
//           never shows a half-updated number.
//
// Handshake: load is a single-cycle request, sampled on the rising edge of
//   clk. A load is accepted when FRAME_LOAD=0, or when the accept flag is set
//   or frame_sync is high in the same cycle. An accepted load always captures
//   value; if a conversion is already running it is queued (latest value
//   wins) and started right after COMMIT. done pulses for one cycle in the
//   cycle the new digits first appear; busy covers the conversion window.
//
// Configuration macro:
//   BCD_SAT_EN - defined: |value| > 9999 shows 9999 and raises ovf.
//                undefined: digits are |value| mod 10000, ovf tied to 0.
//
// Parameters:
//   WIDTH       - width of the signed input value (16)
//   FRAME_LOAD  - 1: one accepted load per frame; 0: every load accepted
// Ports:
//   clk         in  1      system clock
//   rst_n       in  1      asynchronous active-low reset
//   value       in  WIDTH  signed number to display
//   load        in  1      single-cycle convert request
//   frame_sync  in  1      frame start pulse, re-arms load acceptance
//   znak        out 1      1 = value negative
//   cifra_XXXX  out 4      thousands digit
//   cifra_XXX   out 4      hundreds digit
//   cifra_XX    out 4      tens digit
//   cifra_X     out 4      units digit
//   busy        out 1      conversion in progress
//   done        out 1      one-cycle pulse when the digits update
//   ovf         out 1      |value| > 9999 on the last conversion
//   dbg_state   out 2      current FSM state (state_t encoding)
// ============================================================================
module value_bcd_digits
    import value_bcd_digits_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAME_LOAD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             frame_sync,
    output logic             znak,
    output logic [3:0]       cifra_XXXX,
    output logic [3:0]       cifra_XXX,
    output logic [3:0]       cifra_XX,
    output logic [3:0]       cifra_X,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int SR_W  = BCD_BITS + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_hold;
    logic              r_pending;
    logic              r_accept;
    logic              r_sign;
    logic [SR_W-1:0]   r_shift;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_znak;
    logic [3:0]        r_d3;
    logic [3:0]        r_d2;
    logic [3:0]        r_d1;
    logic [3:0]        r_d0;
    logic              r_busy;
    logic              r_done;

    logic              w_load_ok;
    logic [WIDTH-1:0]  w_mag;
    logic [SR_W-1:0]   w_step;
    logic [BCD_BITS-1:0] w_bcd;
    logic              w_over;

    // frame_sync in the same cycle as load counts as already re-armed.
    assign w_load_ok = load && ((FRAME_LOAD == 0) || r_accept || frame_sync);

    // Held unsigned, so the most negative input maps to 2^(WIDTH-1).
    assign w_mag  = r_hold[WIDTH-1] ? (~r_hold + 1'b1) : r_hold;
    assign w_bcd  = r_shift[SR_W-1 -: BCD_BITS];
    assign w_over = |w_bcd[BCD_BITS-1 -: BCD_W];

    dd_step #(
        .WIDTH (WIDTH)
    ) u_dd_step (
        .i_shift (r_shift),
        .o_shift (w_step)
    );

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load_ok) w_next = ABS;
            ABS:     w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST_CNT) w_next = COMMIT;
            // A load arriving during COMMIT itself is folded into the
            // restart decision so it is never stranded in IDLE.
            COMMIT:  w_next = (r_pending || w_load_ok) ? ABS : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Load capture, frame gating and queued restart
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_accept  <= 1'b1;
        end else begin
            if (w_load_ok) begin
                r_hold <= value;
            end

            if (FRAME_LOAD != 0) begin
                if (w_load_ok) begin
                    r_accept <= 1'b0;
                end else if (frame_sync) begin
                    r_accept <= 1'b1;
                end
            end

            if (r_state == COMMIT) begin
                r_pending <= 1'b0;
            end else if (w_load_ok && (r_state != IDLE)) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ABS: begin
                    r_sign  <= r_hold[WIDTH-1];
                    r_shift <= {{BCD_BITS{1'b0}}, w_mag};
                    r_cnt   <= '0;
                end
                SHIFT: begin
                    r_shift <= w_step;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status: busy trails the state by one cycle so it stays high through
    // the cycle in which done reports the new digits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == COMMIT);
        end
    end

    // ------------------------------------------------------------------
    // Output registers, written only in COMMIT
    // ------------------------------------------------------------------
`ifdef BCD_SAT_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_znak <= 1'b0;
            r_d3   <= 4'd0;
            r_d2   <= 4'd0;
            r_d1   <= 4'd0;
            r_d0   <= 4'd0;
            r_ovf  <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_znak <= r_sign;
            r_ovf  <= w_over;
            if (w_over) begin
                r_d3 <= 4'd9;
                r_d2 <= 4'd9;
                r_d1 <= 4'd9;
                r_d0 <= 4'd9;
            end else begin
                r_d3 <= w_bcd[15:12];
                r_d2 <= w_bcd[11:8];
                r_d1 <= w_bcd[7:4];
                r_d0 <= w_bcd[3:0];
            end
        end
    end

    assign ovf = r_ovf;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_znak <= 1'b0;
            r_d3   <= 4'd0;
            r_d2   <= 4'd0;
            r_d1   <= 4'd0;
            r_d0   <= 4'd0;
        end else if (r_state == COMMIT) begin
            r_znak <= r_sign;
            r_d3   <= w_bcd[15:12];
            r_d2   <= w_bcd[11:8];
            r_d1   <= w_bcd[7:4];
            r_d0   <= w_bcd[3:0];
        end
    end

    // The top decade is simply dropped (mod 10000).
    logic w_unused_over;
    assign w_unused_over = w_over;
    assign ovf = 1'b0;
`endif

    assign znak       = r_znak;
    assign cifra_XXXX = r_d3;
    assign cifra_XXX  = r_d2;
    assign cifra_XX   = r_d1;
    assign cifra_X    = r_d0;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_value_bcd_digits.sv
// ============================================================================
// tb_value_bcd_digits
// ----------------------------------------------------------------------------
// Directed bench for value_bcd_digits. Two instances share clock and reset:
// u_dut1 with FRAME_LOAD=1 and u_dut0 with FRAME_LOAD=0. Expected values are
// hand-computed decimal digits of each input. Honour BCD_SAT_EN the same way
// as the design when compiling.
// ============================================================================
module tb_value_bcd_digits;

    logic        clk;
    logic        rst_n;

    logic [15:0] v1, v0;
    logic        ld1, ld0, fs1, fs0;
    logic        znak1, znak0;
    logic [3:0]  d3_1, d2_1, d1_1, d0_1;
    logic [3:0]  d3_0, d2_0, d1_0, d0_0;
    logic        busy1, busy0, done1, done0, ovf1, ovf0;
    logic [1:0]  st1, st0;

    int total = 0;
    int bad   = 0;

    value_bcd_digits #(.WIDTH(16), .FRAME_LOAD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .value(v1), .load(ld1), .frame_sync(fs1),
        .znak(znak1), .cifra_XXXX(d3_1), .cifra_XXX(d2_1), .cifra_XX(d1_1),
        .cifra_X(d0_1), .busy(busy1), .done(done1), .ovf(ovf1), .dbg_state(st1)
    );

    value_bcd_digits #(.WIDTH(16), .FRAME_LOAD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .value(v0), .load(ld0), .frame_sync(fs0),
        .znak(znak0), .cifra_XXXX(d3_0), .cifra_XXX(d2_0), .cifra_XX(d1_0),
        .cifra_X(d0_0), .busy(busy0), .done(done0), .ovf(ovf0), .dbg_state(st0)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out1(input string tag, input logic z, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic o);
        check({tag, ".znak"}, {31'd0, znak1}, {31'd0, z});
        check({tag, ".digits"}, {16'd0, d3_1, d2_1, d1_1, d0_1}, {16'd0, a, b, c, d});
        check({tag, ".ovf"}, {31'd0, ovf1}, {31'd0, o});
    endtask

    // Pulse load on u_dut1, then wait for done; lat = edges from sample to done.
    task automatic conv1(input logic [15:0] v, input logic with_fs, output int lat);
        v1 = v; ld1 = 1'b1; fs1 = with_fs;
        step();
        ld1 = 1'b0; fs1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 40) begin
            step();
            lat++;
            check("busy_during_conv", {31'd0, busy1}, 32'd1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int n_done;
        int first_c, second_c;
        logic [15:0] first_d, second_d;

        rst_n = 1'b0;
        v1 = '0; v0 = '0; ld1 = 0; ld0 = 0; fs1 = 0; fs0 = 0;
        repeat (3) step();

        check("reset_dut1_outputs", {16'd0, d3_1, d2_1, d1_1, d0_1}, 32'd0);
        check("reset_dut1_flags", {28'd0, znak1, busy1, done1, ovf1}, 32'd0);
        check("reset_dut0_outputs", {16'd0, d3_0, d2_0, d1_0, d0_0}, 32'd0);
        check("reset_state", {30'd0, st1}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1234: latency 18, busy cleared the cycle after done
        conv1(16'd1234, 1'b1, lat);
        check("lat_1234", lat, 32'd18);
        check_out1("v1234", 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        step();
        check("done_one_cycle", {31'd0, done1}, 32'd0);
        check("busy_after_done", {31'd0, busy1}, 32'd0);

        // Outputs hold the old number while a new conversion runs.
        v1 = 16'hFFC8; ld1 = 1'b1; fs1 = 1'b1;  // -56
        step();
        ld1 = 1'b0; fs1 = 1'b0;
        repeat (5) step();
        check_out1("hold_mid_conv", 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        lat = 5;
        while (!done1 && lat < 40) begin step(); lat++; end
        check("lat_m56", lat, 32'd18);
        check_out1("vm56", 1'b1, 4'd0, 4'd0, 4'd5, 4'd6, 1'b0);

        conv1(16'd0, 1'b1, lat);
        check("lat_0", lat, 32'd18);
        check_out1("v0", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        conv1(16'h8000, 1'b1, lat);  // -32768
        check("lat_m32768", lat, 32'd18);
`ifdef BCD_SAT_EN
        check_out1("vm32768", 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
`else
        check_out1("vm32768", 1'b1, 4'd2, 4'd7, 4'd6, 4'd8, 1'b0);
`endif

        conv1(16'd12345, 1'b1, lat);
`ifdef BCD_SAT_EN
        check_out1("v12345", 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
`else
        check_out1("v12345", 1'b0, 4'd2, 4'd3, 4'd4, 4'd5, 1'b0);
`endif

        conv1(16'd9999, 1'b1, lat);
        check_out1("v9999", 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0);

        conv1(16'hD8F1, 1'b1, lat);  // -9999
        check_out1("vm9999", 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0);

        // FRAME_LOAD=0: 100 @0, 200 @5, 300 @7 -> 100 @18, 300 @36
        n_done = 0; first_c = -1; second_c = -1; first_d = '0; second_d = '0;
        for (int c = 0; c < 50; c++) begin
            ld0 = (c == 0) || (c == 5) || (c == 7);
            v0  = (c == 0) ? 16'd100 : (c == 5) ? 16'd200 : 16'd300;
            step();
            ld0 = 1'b0;
            if (done0) begin
                n_done++;
                if (n_done == 1) begin first_c = c; first_d = {d3_0, d2_0, d1_0, d0_0}; end
                if (n_done == 2) begin second_c = c; second_d = {d3_0, d2_0, d1_0, d0_0}; end
            end
        end
        check("fl0_done_count", n_done, 32'd2);
        check("fl0_first_cycle", first_c, 32'd18);
        check("fl0_first_digits", {16'd0, first_d}, 32'h0100);
        check("fl0_second_cycle", second_c, 32'd36);
        check("fl0_second_digits", {16'd0, second_d}, 32'h0300);

        // FRAME_LOAD=1: second load without frame_sync is dropped
        fs1 = 1'b1; step(); fs1 = 1'b0;
        v1 = 16'd5; ld1 = 1'b1; step(); ld1 = 1'b0;
        repeat (3) step();
        v1 = 16'd7; ld1 = 1'b1; step(); ld1 = 1'b0;
        lat = 4;
        while (!done1 && lat < 40) begin step(); lat++; end
        check("fl1_first_lat", lat, 32'd18);
        check_out1("fl1_first", 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
        v1 = 16'd7; ld1 = 1'b1; step(); ld1 = 1'b0;
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done1) n_done++;
        end
        check("fl1_dropped_no_done", n_done, 32'd0);
        check_out1("fl1_dropped_hold", 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
        fs1 = 1'b1; step(); fs1 = 1'b0;
        conv1(16'd7, 1'b0, lat);
        check("fl1_rearmed_lat", lat, 32'd18);
        check_out1("fl1_rearmed", 1'b0, 4'd0, 4'd0, 4'd0, 4'd7, 1'b0);

        // Reset in the middle of converting 4321
        v1 = 16'd4321; ld1 = 1'b1; fs1 = 1'b1; step(); ld1 = 1'b0; fs1 = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_digits", {16'd0, d3_1, d2_1, d1_1, d0_1}, 32'd0);
        check("rst_mid_flags", {28'd0, znak1, busy1, done1, ovf1}, 32'd0);
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done1) n_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done1) n_done++;
        end
        check("rst_no_done", n_done, 32'd0);
        check("rst_idle", {30'd0, st1}, 32'd0);
        // Accept flag comes out of reset armed, so no frame_sync needed.
        conv1(16'd4321, 1'b0, lat);
        check("after_rst_lat", lat, 32'd18);
        check_out1("after_rst", 1'b0, 4'd4, 4'd3, 4'd2, 4'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
